fmul_param: RTL
===============

# fmul_param

Parametrised, multi-cycle IEEE-style floating-point multiplier; the next generation of the team's 16-bit `fmul`. It runs the significand product through an internal shift-add datapath at one bit per clock, then normalises, rounds to nearest-even and checks the exponent range. Beyond `fmul` it adds configurable exponent/mantissa widths, a hidden bit, bias correction, rounding, underflow detection and zero/Inf/NaN handling. It sits between the DNN CPU's operand registers and the accumulator, using the same `enable`/`done` handshake as `fmul`.

## Interface
- `EW`, default 5: exponent field width (≥3).
- `MW`, default 10: stored mantissa width (≥4).
- `W`, default EW+MW+1: total word width (derived, do not override).
- `BIAS`, default 2^(EW-1)-1: exponent bias (derived).
- `clk` in, 1: single clock; all logic is on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `enable` in, 1: start request; sampled only in IDLE.
- `f1`, `f2` in, W: operands {sign, exponent, mantissa}; latched when `enable` is accepted.
- `f` out, W: result; held until the next `done`.
- `v` out, 1: overflow flag for the last result; held.
- `uf` out, 1: underflow flag for the last result; held.
- `done` out, 1: one-cycle pulse when `f`, `v` and `uf` update.
- `busy` out, 1: high whenever state ≠ IDLE.

## Operation
- Reset: state IDLE; `f`, `v`, `uf`, `done` and `busy` are 0; all internal registers are cleared. Reset asserted mid-operation aborts the operation, and no `done` is produced for it.
- States: IDLE, MUL, NORM, ROUND, CHECK.
- IDLE:
  - `enable` is ignored in every state other than IDLE.
  - On `enable`=1, latch the operands.
  - A field with exp=0 is treated as zero; subnormals are flushed to zero.
  - If either operand is special (zero, or exp all-ones), set the special flag and go to CHECK.
  - Otherwise load the significands {1,mant}, clear the (2MW+2)-bit product P, set the counter to MW+1 and go to MUL.
- MUL: each cycle performs one shift-add step on the multiplier LSB and decrements the counter. When the counter reaches 0, go to NORM.
- NORM:
  - If P[2MW+1]=1: mantissa m=P[2MW:MW+1], guard g=P[MW], sticky s=|P[MW-1:0], exponent adjust +1.
  - Else: m=P[2MW-1:MW], g=P[MW-1], s=|P[MW-2:0], adjust 0.
  - Go to ROUND.
- ROUND:
  - Round to nearest-even: increment m when g & (s | m[0]).
  - If the increment carries out, m=0 and exponent adjust +1.
  - Go to CHECK.
- CHECK:
  - Compute the exponent as signed EW+2 bits: e = e1 + e2 − BIAS + adjust.
  - Overflow, when e ≥ 2^EW−1: `f`={s,all-ones,0} (±Inf), `v`=1.
  - Underflow, when e ≤ 0: `f`={s,0,0}, `uf`=1.
  - Otherwise `f`={s,e[EW-1:0],m} and both flags are 0.
  - Sign s = f1[W-1] ^ f2[W-1] in all cases.
  - Special-path results, with `v`=`uf`=0:
    - NaN operand, or Inf×0: canonical NaN {0,all-ones,1,0…0}.
    - Inf×finite or Inf×Inf: ±Inf.
    - Zero×finite: ±0.
  - Then pulse `done`, clear `busy` and return to IDLE.

## Timing
- Call the edge that samples `enable` in IDLE edge 0.
- Normal path: MUL occupies edges 1..MW+1, NORM edge MW+2, ROUND edge MW+3, CHECK edge MW+4.
  - `done` is high in the cycle after edge MW+4, which is 14 clocks for the defaults.
- Special path: CHECK at edge 1; `done` is high in the cycle after edge 1.
- `busy` rises after edge 0 and falls together with the `done` pulse.
- Back-to-back operation: the cycle in which `done` is high is IDLE, so an `enable` sampled on that edge is accepted.
- Operand changes after edge 0 have no effect on the result.
- `f`, `v` and `uf` change only on a `done` edge or on reset.

## Test plan
- 0x3E00 × 0x4000 (1.5×2) → `f`=0x4200, `v`=`uf`=0; `done` exactly 14 clocks after `enable`; `busy` high for 14 cycles.
- Round-to-nearest-even tie: 0x3C01 × 0x3E00 → 0x3E02. Sticky case: 0x3C01 × 0x3C01 → 0x3C02.
- Overflow 0x7BFF × 0x7BFF → 0x7C00 with `v`=1. Underflow 0x0400 × 0x0400 → 0x0000 with `uf`=1.
- Signs and specials:
  - 0xC000 × 0x3C00 → 0xC000.
  - 0x7C00 × 0x0000 → 0x7E00.
  - 0xFC00 × 0x4000 → 0xFC00.
  - 0x0000 × 0x5000 → 0x0000.
  - Each special case gives `done` after 1 clock.
- Reset asserted during MUL (edge 5):
  - All outputs are 0 and no `done` is produced.
  - A following 0x4000 × 0x4000 → 0x4400.
- Handshake: `enable` held high across two operations → the second is accepted on the `done` edge. `enable` pulses while `busy` are ignored. Varying `f1` during MUL does not change `f`.

Source files
------------

// File: rtl/fmul_param.sv
// ============================================================================
// Module      : fmul_param
// Description : Parametrised multi-cycle floating-point multiplier with a
//               bit-serial shift-add significand product, round-to-nearest-even,
//               overflow/underflow flags and zero/Inf/NaN handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmul_param #(
    parameter int EW   = 5,
    parameter int MW   = 10,
    parameter int W    = EW + MW + 1,
    parameter int BIAS = (1 << (EW - 1)) - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] f1,
    input  logic [W-1:0] f2,
    output logic [W-1:0] f,
    output logic         v,
    output logic         uf,
    output logic         done,
    output logic         busy
);

    localparam int PW   = 2 * MW + 2;
    localparam int CNTW = $clog2(MW + 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;

    localparam logic [EW+1:0] c_bias = BIAS[EW+1:0];
    localparam logic [EW+1:0] c_emax = (EW + 2)'((1 << EW) - 1);
    localparam logic [W-1:0]  c_nan  = {1'b0, {EW{1'b1}}, 1'b1, {(MW - 1){1'b0}}};

    logic [2:0]      r_state;
    logic [W-1:0]    r_f1, r_f2;
    logic            r_special;
    logic [PW-1:0]   r_mcand, r_p;
    logic [MW:0]     r_mplier;
    logic [CNTW-1:0] r_cnt;
    logic [MW-1:0]   r_m;
    logic            r_g, r_s;
    logic [1:0]      r_adj;
    logic [W-1:0]    r_f;
    logic            r_v, r_uf, r_done, r_busy;

    // Operand classification: exponent 0 flushes to zero, all-ones is Inf/NaN
    logic [EW-1:0] w_e1, w_e2;
    logic          w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;
    logic          w_in_special, w_sign, w_round_up;
    logic [EW+1:0] w_exp;
    logic          w_ovf, w_unf;

    assign w_e1    = r_f1[W-2:MW];
    assign w_e2    = r_f2[W-2:MW];
    assign w_zero1 = (w_e1 == '0);
    assign w_zero2 = (w_e2 == '0);
    assign w_inf1  = (&w_e1) && (r_f1[MW-1:0] == '0);
    assign w_inf2  = (&w_e2) && (r_f2[MW-1:0] == '0);
    assign w_nan1  = (&w_e1) && (r_f1[MW-1:0] != '0);
    assign w_nan2  = (&w_e2) && (r_f2[MW-1:0] != '0);
    assign w_sign  = r_f1[W-1] ^ r_f2[W-1];

    assign w_in_special = (f1[W-2:MW] == '0) || (&f1[W-2:MW]) ||
                          (f2[W-2:MW] == '0) || (&f2[W-2:MW]);

    assign w_round_up = r_g & (r_s | r_m[0]);

    // Biased exponent kept two bits wider so under/overflow stay unambiguous
    assign w_exp = {2'b00, w_e1} + {2'b00, w_e2} - c_bias + {{EW{1'b0}}, r_adj};
    assign w_ovf = ($signed(w_exp) >= $signed(c_emax));
    assign w_unf = ($signed(w_exp) <= $signed((EW + 2)'(0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_f1      <= '0;
            r_f2      <= '0;
            r_special <= 1'b0;
            r_mcand   <= '0;
            r_p       <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_m       <= '0;
            r_g       <= 1'b0;
            r_s       <= 1'b0;
            r_adj     <= '0;
            r_f       <= '0;
            r_v       <= 1'b0;
            r_uf      <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_f1      <= f1;
                        r_f2      <= f2;
                        r_busy    <= 1'b1;
                        r_special <= w_in_special;
                        r_adj     <= '0;
                        if (w_in_special) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_mcand  <= {{(MW + 1){1'b0}}, 1'b1, f1[MW-1:0]};
                            r_mplier <= {1'b1, f2[MW-1:0]};
                            r_p      <= '0;
                            r_cnt    <= CNTW'(MW + 1);
                            r_state  <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_p <= r_p + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == CNTW'(1)) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_p[PW-1]) begin
                        r_m   <= r_p[2*MW:MW+1];
                        r_g   <= r_p[MW];
                        r_s   <= |r_p[MW-1:0];
                        r_adj <= 2'd1;
                    end else begin
                        r_m   <= r_p[2*MW-1:MW];
                        r_g   <= r_p[MW-1];
                        r_s   <= |r_p[MW-2:0];
                        r_adj <= 2'd0;
                    end
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (w_round_up) begin
                        if (&r_m) begin
                            r_m   <= '0;
                            r_adj <= r_adj + 2'd1;
                        end else begin
                            r_m <= r_m + 1'b1;
                        end
                    end
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_v  <= 1'b0;
                    r_uf <= 1'b0;
                    if (r_special) begin
                        if (w_nan1 || w_nan2 || (w_inf1 && w_zero2) || (w_inf2 && w_zero1)) begin
                            r_f <= c_nan;
                        end else if (w_inf1 || w_inf2) begin
                            r_f <= {w_sign, {EW{1'b1}}, {MW{1'b0}}};
                        end else begin
                            r_f <= {w_sign, {(EW + MW){1'b0}}};
                        end
                    end else if (w_ovf) begin
                        r_f <= {w_sign, {EW{1'b1}}, {MW{1'b0}}};
                        r_v <= 1'b1;
                    end else if (w_unf) begin
                        r_f  <= {w_sign, {(EW + MW){1'b0}}};
                        r_uf <= 1'b1;
                    end else begin
                        r_f <= {w_sign, w_exp[EW-1:0], r_m};
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign f    = r_f;
    assign v    = r_v;
    assign uf   = r_uf;
    assign done = r_done;
    assign busy = r_busy;

endmodule

`default_nettype wire
